pipe_stage_buf: RTL and testbench
=================================

// Module: pipe_stage_buf
// PURPOSE
//  Parametrised valid/ready pipeline stage register for the npc core. It is the
//  generic successor of the hand-wired D->X stage latch, sitting between any two
//  pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  It carries a packed WIDTH-bit payload through a DEPTH-entry elastic buffer.
//  It adds back-pressure, a flush for branch/trap redirect and an occupancy count.
// PARAMETERS
//  WIDTH     32   payload width in bits (callers pack the control+data bundle)
//  DEPTH     2    buffer entries; power of 2, >=2 (2 = full-throughput skid)
//  RST_DATA  0    value driven on m_data while the buffer is empty
// PORTS
//  clk      in   1                 clock, rising edge
//  rst      in   1                 synchronous reset, active-high
//  flush    in   1                 drop all held entries (redirect/ecall/mret)
//  s_valid  in   1                 upstream payload valid
//  s_ready  out  1                 buffer can accept this cycle
//  s_data   in   WIDTH             upstream payload
//  m_valid  out  1                 head entry valid to downstream
//  m_ready  in   1                 downstream accepts head
//  m_data   out  WIDTH             head payload
//  count    out  $clog2(DEPTH+1)   current occupancy
// BEHAVIOUR
//  - Reset (rst=1 at posedge): pointers=0, count=0; outputs m_valid=0, s_ready=1,
//    m_data=RST_DATA, count=0. Storage array is not reset.
//  - push = s_valid & s_ready; pop = m_valid & m_ready; both evaluated per cycle.
//  - s_ready = (count != DEPTH). It depends only on registered state, with no
//    combinational m_ready->s_ready path. When full, a push is refused even if a
//    pop happens in the same cycle.
//  - m_valid = (count != 0); m_data = mem[rd_ptr] when valid, else RST_DATA.
//  - Latency: without bypass, an accepted payload appears on m_data the next cycle.
//  - Simultaneous push+pop when 0<count<DEPTH: count unchanged, both pointers advance.
//  - Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
//  - count is updated as +1 (push only), -1 (pop only) or 0 (both or neither).
//    It never exceeds DEPTH and never underflows.
//  - flush=1: next cycle count=0 and rd_ptr=wr_ptr=0. Flush overrides push and pop
//    in the same cycle, so s_data presented that cycle is discarded. m_valid may
//    still be 1 during the flush cycle; the consumer ignores it under flush.
//  - rst has priority over flush. A reset mid-stream discards all entries.
//  - Data stability: while m_valid & ~m_ready, m_data and m_valid hold steady.
// CONFIGURATION
//  PIPE_STAGE_BYPASS_EN defined:
//   - When count==0 and m_ready=1, s_valid/s_data pass combinationally to
//     m_valid/m_data. This gives zero latency and the entry is not written.
//   - This is single-cycle mode: with m_ready tied 1 the block degenerates to wires.
//   - flush still suppresses the bypass (m_valid=0 under flush when empty).
//  PIPE_STAGE_BYPASS_EN undefined:
//   - Always registered; minimum latency 1 cycle; no s->m combinational path.
// STRUCTURE
//  - Shared package npc_pipe_pkg holds the per-stage payload width localparams,
//    for example ID_EX_W = sum of the D->X bundle fields. It also holds the
//    pack/unpack field offsets, so each stage's bundle layout is defined once.
//  - One sub-module, pipe_stage_mem, is the DEPTH x WIDTH register array: a
//    single write port (we, waddr, wdata) and an async read port.
//  - Pointer/count control logic stays in pipe_stage_buf.
// TESTING
//  - Reset: hold rst 2 cycles with s_valid=1 -> m_valid=0, s_ready=1, count=0,
//    m_data=RST_DATA. There is no capture while rst=1.
//  - Streaming: m_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> outputs
//    0x11,0x22,0x33 one cycle later each, count stays 1, no bubbles.
//  - Back-pressure: DEPTH=2, m_ready=0, push 0xA,0xB,0xC -> s_ready=0 after the 2nd
//    push; 0xC is held upstream. Raising m_ready then drains A,B,C in order.
//  - Full with simultaneous pop: count=2, s_valid=1, m_ready=1 -> pop accepted,
//    push refused, count becomes 1.
//  - Flush: count=2 plus push 0x55 in the same cycle as flush -> next cycle
//    count=0, m_valid=0. 0x55 never appears.
//  - Bypass (PIPE_STAGE_BYPASS_EN): empty, m_ready=1, s_data=0xDEAD -> m_data=0xDEAD
//    in the same cycle, count stays 0. Without the macro, it appears one cycle later.

Source files
------------

// File: rtl/npc_pipe_pkg.sv
// Stage payload layouts shared by every pipe_stage_buf instance in the npc core.
// Each bundle's field widths and LSB offsets are defined here and nowhere else.
package npc_pipe_pkg;

  localparam int PIPE_DEFAULT_W     = 32;
  localparam int PIPE_DEFAULT_DEPTH = 2;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_e;

  // IF->ID: pc | instr
  localparam int IFD_INSTR_LSB = 0;
  localparam int IFD_PC_LSB    = IFD_INSTR_LSB + XLEN;
  localparam int IF_ID_W       = IFD_PC_LSB + XLEN;

  // ID->EX: pc | rs1 | rs2 | imm | rd | alu_op | {wb_en, mem_rd, mem_wr}
  localparam int IDX_CTL_W   = 3;
  localparam int IDX_ALU_W   = 4;
  localparam int IDX_CTL_LSB = 0;
  localparam int IDX_ALU_LSB = IDX_CTL_LSB + IDX_CTL_W;
  localparam int IDX_RD_LSB  = IDX_ALU_LSB + IDX_ALU_W;
  localparam int IDX_IMM_LSB = IDX_RD_LSB + REG_AW;
  localparam int IDX_RS2_LSB = IDX_IMM_LSB + XLEN;
  localparam int IDX_RS1_LSB = IDX_RS2_LSB + XLEN;
  localparam int IDX_PC_LSB  = IDX_RS1_LSB + XLEN;
  localparam int ID_EX_W     = IDX_PC_LSB + XLEN;

  // EX->MEM: alu_res | store data | rd | {wb_en, mem_rd, mem_wr}
  localparam int EXM_CTL_LSB = 0;
  localparam int EXM_RD_LSB  = EXM_CTL_LSB + IDX_CTL_W;
  localparam int EXM_STD_LSB = EXM_RD_LSB + REG_AW;
  localparam int EXM_RES_LSB = EXM_STD_LSB + XLEN;
  localparam int EX_MEM_W    = EXM_RES_LSB + XLEN;

  // MEM->WB: wb_data | rd | wb_en
  localparam int MWB_EN_LSB   = 0;
  localparam int MWB_RD_LSB   = MWB_EN_LSB + 1;
  localparam int MWB_DATA_LSB = MWB_RD_LSB + REG_AW;
  localparam int MEM_WB_W     = MWB_DATA_LSB + XLEN;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rd;
    alu_op_e           alu_op;
    logic              wb_en;
    logic              mem_rd;
    logic              mem_wr;
  } id_ex_t;

  typedef struct packed {
    logic [XLEN-1:0]   alu_res;
    logic [XLEN-1:0]   st_data;
    logic [REG_AW-1:0] rd;
    logic              wb_en;
    logic              mem_rd;
    logic              mem_wr;
  } ex_mem_t;

  typedef struct packed {
    logic [XLEN-1:0]   wb_data;
    logic [REG_AW-1:0] rd;
    logic              wb_en;
  } mem_wb_t;

  function automatic logic [IF_ID_W-1:0] pack_if_id(input if_id_t b);
    return b;
  endfunction

  function automatic if_id_t unpack_if_id(input logic [IF_ID_W-1:0] v);
    return if_id_t'(v);
  endfunction

  function automatic logic [ID_EX_W-1:0] pack_id_ex(input id_ex_t b);
    return b;
  endfunction

  function automatic id_ex_t unpack_id_ex(input logic [ID_EX_W-1:0] v);
    return id_ex_t'(v);
  endfunction

  function automatic logic [EX_MEM_W-1:0] pack_ex_mem(input ex_mem_t b);
    return b;
  endfunction

  function automatic ex_mem_t unpack_ex_mem(input logic [EX_MEM_W-1:0] v);
    return ex_mem_t'(v);
  endfunction

  function automatic logic [MEM_WB_W-1:0] pack_mem_wb(input mem_wb_t b);
    return b;
  endfunction

  function automatic mem_wb_t unpack_mem_wb(input logic [MEM_WB_W-1:0] v);
    return mem_wb_t'(v);
  endfunction

  // Hazard logic peeks at rd in flight without unpacking the whole bundle.
  function automatic logic [REG_AW-1:0] id_ex_rd(input logic [ID_EX_W-1:0] v);
    return v[IDX_RD_LSB +: REG_AW];
  endfunction

  function automatic logic [REG_AW-1:0] ex_mem_rd(input logic [EX_MEM_W-1:0] v);
    return v[EXM_RD_LSB +: REG_AW];
  endfunction

  function automatic logic [REG_AW-1:0] mem_wb_rd(input logic [MEM_WB_W-1:0] v);
    return v[MWB_RD_LSB +: REG_AW];
  endfunction

endpackage

// File: rtl/pipe_stage_mem.sv
// DEPTH x WIDTH storage for pipe_stage_buf: one synchronous write port and an
// asynchronous read port. Contents are deliberately not reset.
module pipe_stage_mem
  import npc_pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_DEFAULT_W,
  parameter int DEPTH = PIPE_DEFAULT_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready elastic pipeline stage with flush and occupancy count.
// Optional macro PIPE_STAGE_BYPASS_EN adds a zero-latency path when empty.
module pipe_stage_buf
  import npc_pipe_pkg::*;
#(
  parameter int               WIDTH    = PIPE_DEFAULT_W,
  parameter int               DEPTH    = PIPE_DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RST_DATA = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [WIDTH-1:0]           s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [WIDTH-1:0]           m_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int            PW       = $clog2(DEPTH);
  localparam int            CW       = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [WIDTH-1:0] mem_rdata;
  logic             held_valid;
  logic             push;
  logic             pop;
  logic             store;
  logic             mem_we;

  // s_ready looks only at registered occupancy, so no m_ready->s_ready path.
  assign held_valid = (count_q != '0);
  assign s_ready    = (count_q != FULL_CNT);
  assign push       = s_valid & s_ready;
  assign pop        = held_valid & m_ready;
  assign count      = count_q;

`ifdef PIPE_STAGE_BYPASS_EN
  logic bypass;

  // Reset and flush both block the shortcut so m_valid stays low under either.
  assign bypass = ~held_valid & m_ready & ~flush & ~rst;
  assign store  = push & ~bypass;

  always_comb begin
    m_valid = held_valid;
    m_data  = held_valid ? mem_rdata : RST_DATA;
    if (bypass) begin
      m_valid = s_valid;
      m_data  = s_valid ? s_data : RST_DATA;
    end
  end
`else
  assign store = push;

  always_comb begin
    m_valid = held_valid;
    m_data  = held_valid ? mem_rdata : RST_DATA;
  end
`endif

  assign mem_we = store & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (store) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
      case ({store, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  pipe_stage_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (s_data),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf (WIDTH=32, DEPTH=2, non-zero RST_DATA);
// follows PIPE_STAGE_BYPASS_EN when defined for the build.
module tb_pipe_stage_buf;

  localparam int          W       = 32;
  localparam int          D       = 2;
  localparam logic [31:0] RST_VAL = 32'h0BAD_F00D;
`ifdef PIPE_STAGE_BYPASS_EN
  localparam int STREAM_CNT = 0;
`else
  localparam int STREAM_CNT = 1;
`endif

  logic         clk;
  logic         rst;
  logic         flush;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic [1:0]   count;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q [$];

  pipe_stage_buf #(
    .WIDTH    (W),
    .DEPTH    (D),
    .RST_DATA (RST_VAL)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted output beat must match the oldest expected payload.
  always @(negedge clk) begin
    if (!rst && !flush && m_valid && m_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got %h expected nothing", m_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (m_data !== e) begin
          bad++;
          $display("FAIL sb_data: got %h expected %h", m_data, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] stream_v [3];
    stream_v[0] = 32'h11;
    stream_v[1] = 32'h22;
    stream_v[2] = 32'h33;

    rst = 1'b1; flush = 1'b0; s_valid = 1'b1; s_data = 32'h99; m_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_s_ready", 32'(s_ready), 32'd1);
      chk("rst_count",   32'(count),   32'd0);
      chk("rst_m_data",  m_data,       RST_VAL);
    end
    rst = 1'b0; s_valid = 1'b0;
    step();
    chk("rst_no_capture_cnt", 32'(count),   32'd0);
    chk("rst_no_capture_vld", 32'(m_valid), 32'd0);

    // streaming
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = stream_v[i]; exp_q.push_back(stream_v[i]);
      step();
      chk("stream_count", 32'(count), 32'(STREAM_CNT));
`ifndef PIPE_STAGE_BYPASS_EN
      if (i == 0) chk("stream_latency", m_data, 32'h11);
`endif
    end
    s_valid = 1'b0;
    step();
    chk("stream_drained", 32'(count), 32'd0);

    // back-pressure, then full with simultaneous pop
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 32'hA; exp_q.push_back(32'hA);
    step();
    chk("bp_count1",  32'(count),   32'd1);
    chk("bp_ready1",  32'(s_ready), 32'd1);
    s_data = 32'hB; exp_q.push_back(32'hB);
    step();
    chk("bp_count2",  32'(count),   32'd2);
    chk("bp_full",    32'(s_ready), 32'd0);
    s_data = 32'hC;
    step();
    chk("bp_hold_cnt",  32'(count),   32'd2);
    chk("bp_hold_vld",  32'(m_valid), 32'd1);
    chk("bp_hold_data", m_data,       32'hA);
    m_ready = 1'b1;
    step();
    chk("full_pop_count", 32'(count),   32'd1);
    chk("full_pop_ready", 32'(s_ready), 32'd1);
    exp_q.push_back(32'hC);
    step();
    chk("bp_c_in", 32'(count), 32'd1);
    s_valid = 1'b0;
    step();
    chk("bp_empty_cnt", 32'(count),   32'd0);
    chk("bp_empty_vld", 32'(m_valid), 32'd0);

    // flush while full, with a push and pop offered
    m_ready = 1'b0; s_valid = 1'b1;
    s_data = 32'h66; exp_q.push_back(32'h66); step();
    s_data = 32'h77; exp_q.push_back(32'h77); step();
    chk("fl_pre_count", 32'(count), 32'd2);
    flush = 1'b1; s_data = 32'h55; m_ready = 1'b1; exp_q.delete();
    step();
    chk("fl_count",   32'(count),   32'd0);
    chk("fl_m_valid", 32'(m_valid), 32'd0);
    chk("fl_s_ready", 32'(s_ready), 32'd1);
    chk("fl_m_data",  m_data,       RST_VAL);

    // flush with count=1 while a push would otherwise be accepted
    flush = 1'b0; m_ready = 1'b0;
    s_data = 32'h88; exp_q.push_back(32'h88); step();
    chk("fl2_pre_count", 32'(count), 32'd1);
    flush = 1'b1; s_data = 32'h55; exp_q.delete();
    step();
    chk("fl2_count", 32'(count), 32'd0);
    flush = 1'b0; s_data = 32'h99; exp_q.push_back(32'h99);
    step();
    chk("fl2_refill_cnt",  32'(count), 32'd1);
    chk("fl2_refill_data", m_data,     32'h99);
    m_ready = 1'b1; s_valid = 1'b0;
    step();
    chk("fl2_drained", 32'(count), 32'd0);

    // flush while empty suppresses any same-cycle output
    flush = 1'b1; s_valid = 1'b1; s_data = 32'h77; m_ready = 1'b1;
    #1;
    chk("fl_empty_vld", 32'(m_valid), 32'd0);
    step();
    chk("fl_empty_cnt", 32'(count), 32'd0);
    flush = 1'b0; s_valid = 1'b0;
    step();

    // latency from empty: same cycle with bypass, next cycle without
    m_ready = 1'b1; s_valid = 1'b1; s_data = 32'hDEAD; exp_q.push_back(32'hDEAD);
    #1;
`ifdef PIPE_STAGE_BYPASS_EN
    chk("byp_vld",  32'(m_valid), 32'd1);
    chk("byp_data", m_data,       32'hDEAD);
    step();
    s_valid = 1'b0;
    chk("byp_count", 32'(count), 32'd0);
`else
    chk("reg_vld_now", 32'(m_valid), 32'd0);
    step();
    s_valid = 1'b0;
    chk("reg_vld_next",  32'(m_valid), 32'd1);
    chk("reg_data_next", m_data,       32'hDEAD);
    chk("reg_count",     32'(count),   32'd1);
    step();
    chk("reg_drained", 32'(count), 32'd0);
`endif
    step();

    // reset mid-stream discards everything
    m_ready = 1'b0; s_valid = 1'b1;
    s_data = 32'h101; exp_q.push_back(32'h101); step();
    s_data = 32'h202; exp_q.push_back(32'h202); step();
    chk("mr_pre_count", 32'(count), 32'd2);
    rst = 1'b1; exp_q.delete(); m_ready = 1'b1;
    step();
    chk("mr_count", 32'(count),   32'd0);
    chk("mr_vld",   32'(m_valid), 32'd0);
    rst = 1'b0; s_valid = 1'b0;
    step();
    chk("mr_after", 32'(count), 32'd0);

    step();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
